// File: rtl/stopwatch_ctrl_pkg.sv
// Shared state encodings and counter widths for the stopwatch controller.
package stopwatch_pkg;

  localparam int CNT_W = 8;
  localparam int LAP_W = 4;
  localparam logic [LAP_W-1:0] LAP_MAX = 4'd15;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE  = 4'd0;
  localparam state_t ST_RUN   = 4'd1;
  localparam state_t ST_PAUSE = 4'd2;
  localparam state_t ST_DONE  = 4'd3;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and display-stage outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic             start_stop;
  logic             clear;
  logic             lap;
  logic [LAP_W-1:0] data1;
  logic [3:0]       data2;
  logic [CNT_W-1:0] data3;
  logic             tick;

  modport master (
    output start_stop, clear, lap,
    input  data1, data2, data3, tick
  );

  modport slave (
    input  start_stop, clear, lap,
    output data1, data2, data3, tick
  );

endinterface

// File: rtl/stopwatch_ctrl_btn_cond.sv
// Button conditioner: 2-FF synchroniser, rising-edge pulse.
// Define BTN_DEBOUNCE_EN to insert a DEB_CYC-cycle stability filter before the edge detect.
module btn_cond
`ifdef BTN_DEBOUNCE_EN
  #(parameter int DEB_CYC = 16)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1, sync2;
  logic level, level_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  logic [DW-1:0] stable_cnt;

  // The filtered level only follows sync2 once it has disagreed for DEB_CYC cycles in a row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level      <= 1'b0;
      stable_cnt <= '0;
    end else if (sync2 == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == DEB_LAST) begin
      level      <= sync2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + DW'(1);
    end
  end
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) level_d <= 1'b0;
    else        level_d <= level;
  end

  assign pulse = level & ~level_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch/lap controller: seconds prescaler, seconds and lap counters, run/pause FSM.
// Define BTN_DEBOUNCE_EN to debounce the three buttons for DEB_CYC cycles.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV   = 250,
  parameter int MAX_COUNT = 199
`ifdef BTN_DEBOUNCE_EN
  ,
  parameter int DEB_CYC   = 16
`endif
) (
  input logic             clk,
  input logic             reset,
  stopwatch_ctrl_if.slave bus
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SEC_MAX    = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] SEC_PEN    = CNT_W'(MAX_COUNT - 1);

  logic             ss_pulse, clr_pulse, lap_pulse;
  state_t           state;
  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] seconds;
  logic [LAP_W-1:0] laps;
  logic             tick_q;
  logic             tick_now;

  btn_cond
`ifdef BTN_DEBOUNCE_EN
    #(.DEB_CYC(DEB_CYC))
`endif
    u_btn_ss (.clk(clk), .reset(reset), .btn(bus.start_stop), .pulse(ss_pulse));

  btn_cond
`ifdef BTN_DEBOUNCE_EN
    #(.DEB_CYC(DEB_CYC))
`endif
    u_btn_clr (.clk(clk), .reset(reset), .btn(bus.clear), .pulse(clr_pulse));

  btn_cond
`ifdef BTN_DEBOUNCE_EN
    #(.DEB_CYC(DEB_CYC))
`endif
    u_btn_lap (.clk(clk), .reset(reset), .btn(bus.lap), .pulse(lap_pulse));

  assign tick_now = (state == ST_RUN) && (presc == PRESC_LAST);

  // A pause request holds the prescaler on that edge so a resume continues from the same phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (clr_pulse || (state == ST_IDLE && ss_pulse)) begin
        presc <= '0;
      end else if (tick_now) begin
        presc  <= '0;
        tick_q <= 1'b1;
      end else if (state == ST_RUN && !ss_pulse) begin
        presc <= presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seconds <= '0;
      laps    <= '0;
    end else if (clr_pulse) begin
      seconds <= '0;
      laps    <= '0;
    end else begin
      if (tick_now && seconds < SEC_MAX) seconds <= seconds + CNT_W'(1);
      if (state == ST_RUN && lap_pulse && laps != LAP_MAX) laps <= laps + LAP_W'(1);
    end
  end

  // Reaching the terminal count wins over a same-cycle pause request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else if (clr_pulse) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (ss_pulse) state <= ST_RUN;
        ST_RUN: begin
          if (tick_now && seconds == SEC_PEN) state <= ST_DONE;
          else if (ss_pulse)                  state <= ST_PAUSE;
        end
        ST_PAUSE: if (ss_pulse) state <= ST_RUN;
        ST_DONE:  state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign bus.data1 = laps;
  assign bus.data2 = state;
  assign bus.data3 = seconds;
  assign bus.tick  = tick_q;

endmodule
